// File: rtl/song_sequencer.sv
// song_sequencer: play/pause/skip controller in front of song_reader.
// Owns the current song index, the play level and a multi-cycle clear
// pulse that flushes song_reader and the note players on every song change.
module song_sequencer #(
    parameter int NUM_SONGS  = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_button,
    input  logic       next_button,
    input  logic       repeat_en,
    input  logic       song_done,
    output logic       play,
    output logic [1:0] song,
    output logic       player_clear,
    output logic [1:0] status
);

    // State encoding doubles as the status code seen outside.
    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;

    localparam logic [2:0] SONG_COUNT = 3'(NUM_SONGS);
    localparam logic [1:0] LAST_SONG  = 2'(NUM_SONGS - 1);
    localparam logic [3:0] CLR_LAST   = 4'(CLR_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] song_q, song_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;
    logic       resume_q, resume_d;

    logic [2:0] song_inc;
    logic [1:0] song_next;

    // Next song index: increment first, then fold NUM_SONGS back to zero.
    always_comb begin
        song_inc  = {1'b0, song_q} + 3'd1;
        song_next = (song_inc == SONG_COUNT) ? 2'd0 : song_inc[1:0];
    end

    // Transition logic; inputs are only looked at here, never on the outputs.
    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        clr_cnt_d = clr_cnt_q;
        resume_d  = resume_q;
        case (state_q)
            ST_PAUSED: begin
                if (next_button) begin
                    state_d  = ST_CLEAR;
                    song_d   = song_next;
                    resume_d = 1'b0;
                end else if (play_button) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (next_button) begin
                    state_d  = ST_CLEAR;
                    song_d   = song_next;
                    resume_d = 1'b1;
                end else if (song_done) begin
                    state_d = ST_CLEAR;
                    if ((song_q == LAST_SONG) && !repeat_en) begin
                        // End of album without repeat: rewind and stay stopped.
                        song_d   = 2'd0;
                        resume_d = 1'b0;
                    end else begin
                        song_d   = song_next;
                        resume_d = 1'b1;
                    end
                end else if (play_button) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_CLEAR: begin
                // Every pulse arriving here is dropped on purpose.
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = 4'd0;
                    state_d   = resume_q ? ST_PLAYING : ST_PAUSED;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_PAUSED;
                clr_cnt_d = 4'd0;
            end
        endcase
    end

    // State registers; reset is asynchronous so player_clear drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PAUSED;
            song_q    <= 2'd0;
            clr_cnt_q <= 4'd0;
            resume_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            clr_cnt_q <= clr_cnt_d;
            resume_q  <= resume_d;
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        play         = (state_q == ST_PLAYING);
        player_clear = (state_q == ST_CLEAR);
        status       = state_q;
        song         = song_q;
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vector table, async-reset and
// three-song corner cases, then random pulses against a behavioural model.
module tb_song_sequencer;

    localparam int CLR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_button, next_button, repeat_en, song_done;
    logic       play4, clear4, play3, clear3;
    logic [1:0] song4, status4, song3, status3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    song_sequencer #(.NUM_SONGS(4), .CLR_CYCLES(CLR)) dut (
        .clk(clk), .reset(reset), .play_button(play_button),
        .next_button(next_button), .repeat_en(repeat_en), .song_done(song_done),
        .play(play4), .song(song4), .player_clear(clear4), .status(status4)
    );

    song_sequencer #(.NUM_SONGS(3), .CLR_CYCLES(CLR)) dut3 (
        .clk(clk), .reset(reset), .play_button(play_button),
        .next_button(next_button), .repeat_en(repeat_en), .song_done(song_done),
        .play(play3), .song(song3), .player_clear(clear3), .status(status3)
    );

    // Behavioural model: mode 0 stopped, 1 playing, 2 flushing.
    typedef struct {
        int mode;
        int song;
        bit resume;
        int clear_left;
    } model_t;

    model_t m4, m3;

    function automatic model_t model_reset();
        model_t m;
        m.mode = 0; m.song = 0; m.resume = 0; m.clear_left = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input int ns,
                                          input bit p, input bit n, input bit r, input bit d);
        model_t o = m;
        if (m.mode == 2) begin
            o.clear_left = m.clear_left - 1;
            if (o.clear_left == 0) o.mode = m.resume ? 1 : 0;
        end else if (n) begin
            o.song = (m.song + 1) % ns;
            o.resume = (m.mode == 1);
            o.mode = 2; o.clear_left = CLR;
        end else if (m.mode == 1 && d) begin
            if (m.song == ns - 1 && !r) begin
                o.song = 0; o.resume = 0;
            end else begin
                o.song = (m.song + 1) % ns; o.resume = 1;
            end
            o.mode = 2; o.clear_left = CLR;
        end else if (p) begin
            o.mode = (m.mode == 1) ? 0 : 1;
        end
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model4(input string tag);
        check({tag, ".play"},   int'(play4),   int'(m4.mode == 1));
        check({tag, ".song"},   int'(song4),   m4.song);
        check({tag, ".clear"},  int'(clear4),  int'(m4.mode == 2));
        check({tag, ".status"}, int'(status4), m4.mode);
    endtask

    task automatic check_model3(input string tag);
        check({tag, ".play3"},   int'(play3),   int'(m3.mode == 1));
        check({tag, ".song3"},   int'(song3),   m3.song);
        check({tag, ".clear3"},  int'(clear3),  int'(m3.mode == 2));
        check({tag, ".status3"}, int'(status3), m3.mode);
    endtask

    // One clock: drive at negedge, update models past the edge, land on next negedge.
    task automatic cycle(input logic p, input logic n, input logic r, input logic d);
        play_button = p; next_button = n; repeat_en = r; song_done = d;
        @(posedge clk);
        #1;
        m4 = model_step(m4, 4, p, n, r, d);
        m3 = model_step(m3, 3, p, n, r, d);
        play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic p, n, r, d;
        logic ep;
        logic [1:0] es;
        logic ec;
        logic [1:0] est;
    } vec_t;

    vec_t tbl [32];
    int   seen3;

    initial begin
        // p n r d | play song clear status
        tbl[0]  = '{1,0,0,0, 1,0,0,1};
        tbl[1]  = '{0,0,0,0, 1,0,0,1};
        tbl[2]  = '{0,1,0,0, 0,1,1,2};
        tbl[3]  = '{1,0,0,0, 0,1,1,2};
        tbl[4]  = '{0,0,0,0, 1,1,0,1};
        tbl[5]  = '{0,0,0,1, 0,2,1,2};
        tbl[6]  = '{0,0,0,0, 0,2,1,2};
        tbl[7]  = '{0,0,0,0, 1,2,0,1};
        tbl[8]  = '{0,0,0,1, 0,3,1,2};
        tbl[9]  = '{0,0,0,1, 0,3,1,2};
        tbl[10] = '{0,0,0,0, 1,3,0,1};
        tbl[11] = '{0,0,0,1, 0,0,1,2};
        tbl[12] = '{0,0,0,0, 0,0,1,2};
        tbl[13] = '{0,0,0,0, 0,0,0,0};
        tbl[14] = '{1,0,0,0, 1,0,0,1};
        tbl[15] = '{0,1,0,0, 0,1,1,2};
        tbl[16] = '{0,0,0,0, 0,1,1,2};
        tbl[17] = '{0,0,0,0, 1,1,0,1};
        tbl[18] = '{0,1,0,0, 0,2,1,2};
        tbl[19] = '{0,0,0,0, 0,2,1,2};
        tbl[20] = '{0,0,0,0, 1,2,0,1};
        tbl[21] = '{1,1,0,1, 0,3,1,2};
        tbl[22] = '{0,0,0,0, 0,3,1,2};
        tbl[23] = '{0,0,0,0, 1,3,0,1};
        tbl[24] = '{0,0,1,1, 0,0,1,2};
        tbl[25] = '{0,0,0,0, 0,0,1,2};
        tbl[26] = '{0,0,0,0, 1,0,0,1};
        tbl[27] = '{1,0,0,0, 0,0,0,0};
        tbl[28] = '{0,0,0,1, 0,0,0,0};
        tbl[29] = '{0,1,0,0, 0,1,1,2};
        tbl[30] = '{0,0,0,0, 0,1,1,2};
        tbl[31] = '{0,0,0,0, 0,1,0,0};

        reset = 1'b0;
        play_button = 1'b0; next_button = 1'b0; repeat_en = 1'b0; song_done = 1'b0;
        m4 = model_reset();
        m3 = model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.play",   int'(play4),   0);
        check("reset.song",   int'(song4),   0);
        check("reset.clear",  int'(clear4),  0);
        check("reset.status", int'(status4), 0);
        reset = 1'b1;

        // Directed table on the four-song build.
        for (int i = 0; i < 32; i++) begin
            cycle(tbl[i].p, tbl[i].n, tbl[i].r, tbl[i].d);
            $display("vec %0d p=%0b n=%0b r=%0b d=%0b -> play=%0b song=%0d clr=%0b st=%0d",
                     i, tbl[i].p, tbl[i].n, tbl[i].r, tbl[i].d, play4, song4, clear4, status4);
            check($sformatf("vec%0d.play", i),   int'(play4),   int'(tbl[i].ep));
            check($sformatf("vec%0d.song", i),   int'(song4),   int'(tbl[i].es));
            check($sformatf("vec%0d.clear", i),  int'(clear4),  int'(tbl[i].ec));
            check($sformatf("vec%0d.status", i), int'(status4), int'(tbl[i].est));
            check_model3($sformatf("vec%0d", i));
        end

        // Reset arriving in the first CLEAR cycle must act without a clock edge.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("midclr.clear_before", int'(clear4), 1);
        reset = 1'b0;
        #1;
        $display("async reset mid-clear: clr=%0b song=%0d", clear4, song4);
        check("midclr.clear", int'(clear4), 0);
        check("midclr.song",  int'(song4),  0);
        check("midclr.clear3", int'(clear3), 0);
        m4 = model_reset();
        m3 = model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Three-song build: walk to song 2, skip, expect wrap to 0.
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("n3.at_song2", int'(song3), 2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        $display("n3 skip from 2: song=%0d clr=%0b", song3, clear3);
        check("n3.wrap_song", int'(song3), 0);
        check("n3.wrap_clear", int'(clear3), 1);

        // Random pulses; the three-song build must never show index 3.
        seen3 = 0;
        for (int i = 0; i < 420; i++) begin
            logic p, n, r, d;
            p = ($urandom_range(3) == 0);
            n = ($urandom_range(5) == 0);
            r = $urandom_range(1);
            d = ($urandom_range(3) == 0);
            cycle(p, n, r, d);
            if (i < 40)
                $display("rnd %0d p=%0b n=%0b r=%0b d=%0b -> s4=%0d st4=%0d s3=%0d st3=%0d",
                         i, p, n, r, d, song4, status4, song3, status3);
            check_model4($sformatf("rnd%0d", i));
            check_model3($sformatf("rnd%0d", i));
            if (song3 == 2'd3) seen3++;
        end
        check("n3.never_song3", seen3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
